// File: rtl/light_tx_pkg.sv
// Shared types and default timing for the WS2812-style light word transmitter.
// Default cycle counts assume a 50 MHz clock.
package light_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } tx_state_t;

    localparam int DEF_T0H   = 20;
    localparam int DEF_T0L   = 45;
    localparam int DEF_T1H   = 40;
    localparam int DEF_T1L   = 25;
    localparam int DEF_LATCH = 2500;
    localparam int N_BITS    = 24;

    // The LED expects green first, then red, then blue, each MSB first.
    function automatic logic [N_BITS-1:0] grb_order(input logic [N_BITS-1:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/tx_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module tx_timer #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          done
);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/light_serial_tx.sv
// Shifts one captured 24-bit colour word out as pulse-width-coded bits,
// then holds the line low for the latch gap.
module light_serial_tx
    import light_tx_pkg::*;
#(
    parameter int T0H   = DEF_T0H,
    parameter int T0L   = DEF_T0L,
    parameter int T1H   = DEF_T1H,
    parameter int T1L   = DEF_T1L,
    parameter int LATCH = DEF_LATCH,
    parameter int CW    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] light,
    input  logic        valid,
    output logic        ready,
    output logic        dout,
    output logic        busy
);

    // Timer reload values are duration - 1 so a state lasts exactly its duration.
    localparam logic [CW-1:0] T0H_LD   = CW'(T0H - 1);
    localparam logic [CW-1:0] T0L_LD   = CW'(T0L - 1);
    localparam logic [CW-1:0] T1H_LD   = CW'(T1H - 1);
    localparam logic [CW-1:0] T1L_LD   = CW'(T1L - 1);
    localparam logic [CW-1:0] LATCH_LD = CW'(LATCH - 1);

    tx_state_t     state, state_n;
    logic [23:0]   shreg;
    logic [23:0]   light_grb;
    logic [4:0]    bit_idx;
    logic          cur_bit;
    logic          accept;
    logic          timer_load;
    logic [CW-1:0] timer_val;
    logic          timer_done;

    assign light_grb = grb_order(light);
    assign ready     = (state == ST_IDLE);
    assign busy      = !ready;
    assign accept    = valid && ready;

    tx_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .value (timer_val),
        .done  (timer_done)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n    = state;
        timer_load = 1'b0;
        timer_val  = '0;
        unique case (state)
            ST_IDLE: begin
                if (valid) begin
                    state_n    = ST_HIGH;
                    timer_load = 1'b1;
                    timer_val  = light_grb[23] ? T1H_LD : T0H_LD;
                end
            end
            ST_HIGH: begin
                if (timer_done) begin
                    state_n    = ST_LOW;
                    timer_load = 1'b1;
                    timer_val  = cur_bit ? T1L_LD : T0L_LD;
                end
            end
            ST_LOW: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    if (bit_idx == 5'd0) begin
                        state_n   = ST_LATCH;
                        timer_val = LATCH_LD;
                    end else begin
                        // shreg[22] becomes the MSB after this cycle's shift.
                        state_n   = ST_HIGH;
                        timer_val = shreg[22] ? T1H_LD : T0H_LD;
                    end
                end
            end
            ST_LATCH: begin
                if (timer_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            dout    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            cur_bit <= 1'b0;
        end else begin
            state <= state_n;
            dout  <= (state_n == ST_HIGH);
            if (accept) begin
                shreg   <= light_grb;
                bit_idx <= 5'd23;
                cur_bit <= light_grb[23];
            end else if (state == ST_LOW && timer_done) begin
                shreg <= {shreg[22:0], 1'b0};
                if (bit_idx != 5'd0) begin
                    bit_idx <= bit_idx - 5'd1;
                    cur_bit <= shreg[22];
                end
            end
        end
    end

endmodule

// File: tb/tb_light_serial_tx.sv
// Bench for light_serial_tx: a waveform-queue model of the line plus directed
// frames with hand-computed sample points.
module tb_light_serial_tx;

    localparam int P_T0H   = 2;
    localparam int P_T0L   = 3;
    localparam int P_T1H   = 3;
    localparam int P_T1L   = 2;
    localparam int P_LATCH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] light = '0;
    logic        ready;
    logic        dout;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    logic cap_dout  [1:300];
    logic cap_ready [1:300];

    always #5 clk = ~clk;

    light_serial_tx #(
        .T0H   (P_T0H),
        .T0L   (P_T0L),
        .T1H   (P_T1H),
        .T1L   (P_T1L),
        .LATCH (P_LATCH),
        .CW    (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .light (light),
        .valid (valid),
        .ready (ready),
        .dout  (dout),
        .busy  (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the expected line level for each upcoming cycle of the current frame.
    bit exp_q[$];

    task automatic push_frame(input logic [23:0] rgb);
        logic [23:0] w;
        w = {rgb[15:8], rgb[23:16], rgb[7:0]};
        for (int i = 23; i >= 0; i--) begin
            int h;
            int l;
            h = w[i] ? P_T1H : P_T0H;
            l = w[i] ? P_T1L : P_T0L;
            repeat (h) exp_q.push_back(1'b1);
            repeat (l) exp_q.push_back(1'b0);
        end
        repeat (P_LATCH) exp_q.push_back(1'b0);
    endtask

    always @(posedge clk or negedge rst) begin
        bit was_idle;
        if (!rst) begin
            exp_q.delete();
        end else begin
            was_idle = (exp_q.size() == 0);
            if (!was_idle) void'(exp_q.pop_front());
            if (was_idle && valid) push_frame(light);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("dout",  dout,  (exp_q.size() != 0) ? exp_q[0] : 1'b0);
            check("ready", ready, exp_q.size() == 0);
            check("busy",  busy,  exp_q.size() != 0);
        end
    end

    // Offer w, capture n cycles after the accepting edge; afterwards valid is
    // toggled (tog), held with next_light until cycle hold, or dropped.
    task automatic send(input logic [23:0] w, input int n, input int hold,
                        input logic [23:0] next_light, input bit tog, input bit rel_rst);
        @(negedge clk);
        if (rel_rst) rst = 1'b1;
        valid = 1'b1;
        light = w;
        @(posedge clk);
        #1;
        check("model_len", exp_q.size(), 124);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            cap_dout[k]  = dout;
            cap_ready[k] = ready;
            if (tog && k <= 100) begin
                valid = ~valid;
                light = 24'($urandom());
            end else if (k < hold) begin
                valid = 1'b1;
                light = next_light;
            end else begin
                valid = 1'b0;
            end
        end
    endtask

    function automatic int ready_low(input int n);
        int c;
        c = 0;
        for (int k = 1; k <= n; k++) if (cap_ready[k] == 1'b0) c++;
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_ready", ready, 1);
        check("idle_busy",  busy,  0);
        check("idle_dout",  dout,  0);

        // Red: G=00, R=FF, B=00.
        send(24'hFF0000, 126, 0, 24'h0, 1'b0, 1'b0);
        check("red_c1",    cap_dout[1],  1);
        check("red_c2",    cap_dout[2],  1);
        check("red_c3",    cap_dout[3],  0);
        check("red_c41",   cap_dout[41], 1);
        check("red_c43",   cap_dout[43], 1);
        check("red_c44",   cap_dout[44], 0);
        check("red_c81",   cap_dout[81], 1);
        check("red_c83",   cap_dout[83], 0);
        check("red_c121",  cap_dout[121], 0);
        check("red_c124",  cap_dout[124], 0);
        check("red_busy_len", ready_low(126), 124);
        check("red_ready125", cap_ready[125], 1);

        // White: every bit long.
        send(24'hFFFFFF, 126, 0, 24'h0, 1'b0, 1'b0);
        check("wht_c3",   cap_dout[3],   1);
        check("wht_c4",   cap_dout[4],   0);
        check("wht_c118", cap_dout[118], 1);
        check("wht_ready124", cap_ready[124], 0);
        check("wht_ready125", cap_ready[125], 1);

        // Back-to-back: valid held, second word 0000FF waiting.
        send(24'h00FF00, 260, 130, 24'h0000FF, 1'b0, 1'b0);
        check("b2b_c3",   cap_dout[3],   1);
        check("b2b_c125", cap_dout[125], 0);
        check("b2b_ready125", cap_ready[125], 1);
        check("b2b_c126", cap_dout[126], 1);
        check("b2b_c128", cap_dout[128], 0);
        check("b2b_c206", cap_dout[206], 1);
        check("b2b_c208", cap_dout[208], 1);
        check("b2b_busy_len", ready_low(260), 248);

        // Inputs toggling during the frame must not disturb it.
        send(24'h5AC3E1, 126, 0, 24'h0, 1'b1, 1'b0);
        check("tog_c3", cap_dout[3], 1);
        check("tog_busy_len", ready_low(126), 124);
        check("tog_ready125", cap_ready[125], 1);

        // Reset in the high phase of bit 10 (cycles 46..50 after accept).
        send(24'hABCDEF, 45, 0, 24'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_dout", dout, 1);
        rst = 1'b0;
        #1;
        check("rst_dout",  dout,  0);
        check("rst_ready", ready, 1);
        check("rst_busy",  busy,  0);
        repeat (3) @(negedge clk);
        send(24'h123456, 126, 0, 24'h0, 1'b0, 1'b1);
        check("post_c3",  cap_dout[3],  0);
        check("post_c13", cap_dout[13], 1);
        check("post_busy_len", ready_low(126), 124);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
